// File: rtl/pipeline_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// pipeline_hazard_ctrl
//
// Central sequencer for the 5-stage pipeline. It drives the PC enable and the
// load enable / bubble-flush of the IF_ID, ID_EX, EX_MEM and MEM_WB pipeline
// registers. It also
//   - primes the pipe with bubbles for INIT_CYCLES clocks after reset,
//   - resolves load-use hazards, taken branches (resolved in EX) and
//     multi-cycle data-memory accesses (completed in MEM),
//   - keeps saturating stall/flush counters and a sticky memory-timeout flag.
//
// Ports
//   clk, rst_n             clock (rising edge), async active-low reset
//   i_id_rs1/rs2           ID-stage source registers
//   i_id_use_rs1/rs2       ID instruction actually reads rs1/rs2
//   i_ex_moe, i_ex_rd      EX instruction is a load, and its destination
//   i_ex_br_taken          branch/jump taken, resolved in EX
//   i_mem_moe/mwr          MEM-stage read / write
//   i_mem_ack              data memory completes the access this cycle
//   o_mem_req              data-memory request
//   o_pc_en, o_pc_sel_br   PC update enable, PC loads branch target
//   o_*_en                 pipeline-register load enables
//   o_*_flush              load a bubble instead of data
//   o_stall_cnt            RUN/MEM_WAIT cycles with the PC held (saturating)
//   o_flush_cnt            taken-branch flush events (saturating)
//   o_mem_err              sticky: a memory access timed out
//
// State table
//   state       | meaning
//   ------------+-----------------------------------------------------------
//   ST_INIT     | post-reset bubble priming, PC held, every stage flushed
//   ST_RUN      | normal flow, hazard logic active
//   ST_MEM_WAIT | MEM access outstanding, upstream frozen, bubbles into WB
// ----------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
    parameter int unsigned RAW         = 5,
    parameter int unsigned INIT_CYCLES = 4,
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [RAW-1:0]   i_id_rs1,
    input  logic [RAW-1:0]   i_id_rs2,
    input  logic             i_id_use_rs1,
    input  logic             i_id_use_rs2,
    input  logic             i_ex_moe,
    input  logic [RAW-1:0]   i_ex_rd,
    input  logic             i_ex_br_taken,
    input  logic             i_mem_moe,
    input  logic             i_mem_mwr,
    input  logic             i_mem_ack,
    output logic             o_mem_req,
    output logic             o_pc_en,
    output logic             o_pc_sel_br,
    output logic             o_ifid_en,
    output logic             o_idex_en,
    output logic             o_exmem_en,
    output logic             o_memwb_en,
    output logic             o_ifid_flush,
    output logic             o_idex_flush,
    output logic             o_memwb_flush,
    output logic [CNT_W-1:0] o_stall_cnt,
    output logic [CNT_W-1:0] o_flush_cnt,
    output logic             o_mem_err
);

    typedef enum logic [1:0] {
        ST_INIT     = 2'd0,
        ST_RUN      = 2'd1,
        ST_MEM_WAIT = 2'd2
    } state_t;

    localparam logic [3:0]       LP_INIT_LAST = 4'(INIT_CYCLES - 1);
    localparam logic [7:0]       LP_TIMEOUT   = 8'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0] LP_CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           r_state;
    logic [3:0]       r_init_cnt;
    logic [7:0]       r_wait_cnt;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;
    logic             r_mem_err;

    logic w_acc;
    logic w_timeout;
    logic w_freeze;
    logic w_eval;
    logic w_branch;
    logic w_load_use;

    assign w_acc = i_mem_moe | i_mem_mwr;

    // The wait counter holds the number of frozen cycles already spent on the
    // outstanding access (the RUN cycle that first saw it counts as one). Once
    // MEM_TIMEOUT cycles have been spent, the next cycle without ack drops it.
    assign w_timeout = (r_state == ST_MEM_WAIT) && !i_mem_ack && (r_wait_cnt == LP_TIMEOUT);

    assign w_freeze = ((r_state == ST_RUN) && w_acc && !i_mem_ack) ||
                      ((r_state == ST_MEM_WAIT) && !i_mem_ack && !w_timeout);

    // The MEM_WAIT release cycle also advances EX, so a branch or load-use
    // sitting behind the frozen access must be resolved in that same cycle.
    assign w_eval = ((r_state == ST_RUN) || (r_state == ST_MEM_WAIT)) && !w_freeze;

    assign w_branch = w_eval && i_ex_br_taken;

    assign w_load_use = w_eval && !i_ex_br_taken && i_ex_moe && (i_ex_rd != '0) &&
                        ((i_id_use_rs1 && (i_id_rs1 == i_ex_rd)) ||
                         (i_id_use_rs2 && (i_id_rs2 == i_ex_rd)));

    always_comb begin
        o_mem_req     = 1'b0;
        o_pc_en       = 1'b1;
        o_pc_sel_br   = 1'b0;
        o_ifid_en     = 1'b1;
        o_idex_en     = 1'b1;
        o_exmem_en    = 1'b1;
        o_memwb_en    = 1'b1;
        o_ifid_flush  = 1'b0;
        o_idex_flush  = 1'b0;
        o_memwb_flush = 1'b0;
        case (r_state)
            ST_INIT: begin
                o_pc_en       = 1'b0;
                o_ifid_flush  = 1'b1;
                o_idex_flush  = 1'b1;
                o_memwb_flush = 1'b1;
            end
            ST_RUN, ST_MEM_WAIT: begin
                o_mem_req = (r_state == ST_MEM_WAIT) ? 1'b1 : w_acc;
                if (w_freeze) begin
                    o_pc_en       = 1'b0;
                    o_ifid_en     = 1'b0;
                    o_idex_en     = 1'b0;
                    o_exmem_en    = 1'b0;
                    o_memwb_flush = 1'b1;
                end else begin
                    // A timed-out access is dropped: WB gets a bubble.
                    o_memwb_flush = w_timeout;
                    if (w_branch) begin
                        o_pc_sel_br  = 1'b1;
                        o_ifid_flush = 1'b1;
                        o_idex_flush = 1'b1;
                    end else if (w_load_use) begin
                        o_pc_en      = 1'b0;
                        o_ifid_en    = 1'b0;
                        o_idex_flush = 1'b1;
                    end
                end
            end
            default: begin
                o_pc_en = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_INIT;
            r_init_cnt <= '0;
            r_wait_cnt <= '0;
            r_mem_err  <= 1'b0;
        end else begin
            case (r_state)
                ST_INIT: begin
                    if (r_init_cnt == LP_INIT_LAST) begin
                        r_init_cnt <= '0;
                        r_state    <= ST_RUN;
                    end else begin
                        r_init_cnt <= r_init_cnt + 4'd1;
                    end
                end
                ST_RUN: begin
                    if (w_acc && !i_mem_ack) begin
                        r_wait_cnt <= 8'd1;
                        r_state    <= ST_MEM_WAIT;
                    end
                end
                ST_MEM_WAIT: begin
                    if (i_mem_ack) begin
                        r_wait_cnt <= '0;
                        r_state    <= ST_RUN;
                    end else if (w_timeout) begin
                        r_wait_cnt <= '0;
                        r_mem_err  <= 1'b1;
                        r_state    <= ST_RUN;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 8'd1;
                    end
                end
                default: begin
                    r_state <= ST_INIT;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if ((r_state != ST_INIT) && !o_pc_en && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + LP_CNT_ONE;
            end
            if (o_pc_sel_br && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + LP_CNT_ONE;
            end
        end
    end

    assign o_stall_cnt = r_stall_cnt;
    assign o_flush_cnt = r_flush_cnt;
    assign o_mem_err   = r_mem_err;

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central sequencer for the 5-stage pipeline: produces the PC enable and the per-register enable/flush for IF_ID, ID_EX, EX_MEM and MEM_WB.
- Detects load-use hazards, taken branches resolved in EX, and multi-cycle data-memory accesses in MEM.
- Runs a post-reset bubble-priming sequence.
- Keeps saturating stall/flush performance counters and a sticky memory-timeout error.

Parameters:
- RAW, 5, register-address width.
- INIT_CYCLES, 4, cycles of forced bubbles after reset release; range 1..15.
- MEM_TIMEOUT, 16, maximum wait cycles for mem_ack before abort; range 2..255.
- CNT_W, 16, performance-counter width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_rs1  in  RAW  ID-stage source register 1.
- id_rs2  in  RAW  ID-stage source register 2.
- id_use_rs1  in  1  ID instruction reads rs1.
- id_use_rs2  in  1  ID instruction reads rs2.
- ex_moe  in  1  EX instruction is a load (memory output enable).
- ex_rd  in  RAW  EX destination register.
- ex_br_taken  in  1  branch/jump taken, resolved in EX.
- mem_moe  in  1  MEM-stage read.
- mem_mwr  in  1  MEM-stage write.
- mem_ack  in  1  data memory completes the access this cycle.
- mem_req  out  1  data-memory request.
- pc_en  out  1  PC update enable.
- pc_sel_br  out  1  PC loads branch target.
- ifid_en, idex_en, exmem_en, memwb_en  out  1 each  pipeline-register load enables.
- ifid_flush, idex_flush, memwb_flush  out  1 each  load bubble (NOP) instead of data.
- stall_cnt  out  CNT_W  cycles with pc_en=0 in RUN/MEM_WAIT.
- flush_cnt  out  CNT_W  taken-branch flush events.
- mem_err  out  1  sticky: a memory access timed out.

Behaviour:
- FSM states: INIT, RUN, MEM_WAIT.
- Reset: state=INIT, init counter=0, wait counter=0, stall_cnt=0, flush_cnt=0, mem_err=0.
- INIT: pc_en=0; all *_en=1; all *_flush=1; mem_req=0.
  - Leaves to RUN after exactly INIT_CYCLES clocks.
  - The first fetch enable is in the cycle after the last INIT cycle.
- Memory access: acc = mem_moe|mem_mwr.
- In RUN, mem_req=acc (combinational).
  - If acc=1 and mem_ack=0: freeze this cycle and go to MEM_WAIT with the wait counter set to 1.
- MEM_WAIT:
  - mem_req=1.
  - pc_en=ifid_en=idex_en=exmem_en=0.
  - memwb_en=1 with memwb_flush=1 (bubble into WB).
  - The wait counter increments each cycle.
  - On mem_ack=1: the MEM result passes normally (memwb_flush=0, all enables=1) and the state returns to RUN.
  - When the wait counter reaches MEM_TIMEOUT without ack: set mem_err, force memwb_flush=1 and all enables=1 (access dropped), return to RUN.
  - mem_ack arriving on the timeout cycle counts as success.
- Freeze (RUN with acc&!mem_ack, or MEM_WAIT without completion): all hazard logic is suppressed; EX/ID contents are held and re-evaluated after release.
- Branch (RUN, no freeze, ex_br_taken=1):
  - pc_sel_br=1, pc_en=1.
  - ifid_flush=1, idex_flush=1; all enables=1.
  - flush_cnt+1.
  - Single cycle, with no state change.
- Load-use (RUN, no freeze, no branch):
  - Condition: ex_moe=1, ex_rd!=0, and (id_use_rs1 & id_rs1==ex_rd or id_use_rs2 & id_rs2==ex_rd).
  - Response: pc_en=0, ifid_en=0, idex_flush=1, exmem_en=memwb_en=1.
  - Exactly one bubble; the condition clears naturally the next cycle.
- Priority: freeze > branch > load-use. A branch coincident with load-use flushes and does not stall.
- Default RUN: all enables=1, all flushes=0, pc_sel_br=0.
- Counters:
  - stall_cnt increments on every RUN/MEM_WAIT cycle with pc_en=0.
  - stall_cnt and flush_cnt saturate at all-ones, with no wrap.
- rst_n asserted mid-MEM_WAIT: immediate return to INIT values; mem_req drops asynchronously.
- All enables/flushes are combinational from state and inputs. State, counters and mem_err are registered.

Test Plan:
- Reset release with INIT_CYCLES=4 -> pc_en=0 and all flushes=1 for 4 cycles; pc_en=1 and flushes=0 on cycle 5.
- EX load with ex_rd=5, ID id_rs2=5, id_use_rs2=1 -> one cycle of pc_en=0, ifid_en=0, idex_flush=1; stall_cnt=1; normal flow after.
- Same as the load-use case but ex_rd=0 (or id_use_rs2=0) -> no stall, stall_cnt stays 0.
- mem_mwr=1 with mem_ack low for 3 cycles then high -> PC/IF_ID/ID_EX/EX_MEM held 3 cycles, memwb_flush=1 during the wait, release on the ack cycle; stall_cnt=3.
- mem_moe=1, ack never comes, MEM_TIMEOUT=16 -> mem_err=1 after 16 cycles, pipeline resumes, mem_err stays 1 until reset.
- ex_br_taken=1 together with a load-use match -> pc_sel_br=1, ifid_flush=idex_flush=1, pc_en=1, flush_cnt=1, stall_cnt unchanged.
- rst_n pulsed low during MEM_WAIT -> mem_req=0 immediately, counters=0, INIT sequence restarts.
